// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pkg
// Description : Shared types and default constants for the fetch stage.
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        FAULT = 2'd3
    } fetch_state_t;

    localparam int          DEFAULT_XLEN     = 32;
    localparam int          DEFAULT_DEPTH    = 4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam int          PC_STEP          = 4;

endpackage
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
// Module      : fetch_fifo
// Description : Synchronous prefetch FIFO; flush beats push and pop.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_data,
    input  logic                       i_pop,
    input  logic                       i_flush,
    output logic [WIDTH-1:0]           o_data,
    output logic [$clog2(DEPTH):0]     o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_rd;
    logic [AW-1:0]    r_wr;
    logic [CW-1:0]    r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign w_do_push = i_push & (r_count != CW'(DEPTH));
    assign w_do_pop  = i_pop & (r_count != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd    <= '0;
            r_wr    <= '0;
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_flush) begin
            r_rd    <= '0;
            r_wr    <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr] <= i_data;
                r_wr        <= r_wr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd <= r_rd + AW'(1);
            end
            r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
        end
    end

    assign o_data  = r_mem[r_rd];
    assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit
// Description : Sequential instruction fetch with prefetch queue and redirect
//               flush. FETCH_ALIGN_CHECK_EN enables misaligned-redirect faults.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int              XLEN     = DEFAULT_XLEN,
    parameter int              DEPTH    = DEFAULT_DEPTH,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(DEFAULT_RESET_PC)
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_valid,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_req_ready,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            instr_valid,
    output logic [31:0]     instr,
    output logic [XLEN-1:0] instr_pc,
    input  logic            instr_ready,
    output logic            fetch_fault,
    output logic [XLEN-1:0] fault_pc
);

    localparam int          CW      = $clog2(DEPTH) + 1;
    localparam int          FW      = 32 + XLEN;
    localparam logic [CW:0] C_DEPTH = (CW+1)'(DEPTH);

    fetch_state_t    r_state;
    fetch_state_t    w_state_next;
    logic            r_req_valid;
    logic [XLEN-1:0] r_req_addr;
    logic [XLEN-1:0] r_rsp_pc;
    logic [CW-1:0]   r_outst;
    logic [CW-1:0]   r_discard;
    logic [CW-1:0]   w_outst_next;
    logic [CW-1:0]   w_discard_next;
    logic [CW-1:0]   w_count;
    logic [CW-1:0]   w_count_next;
    logic            w_acc;
    logic            w_pop;
    logic            w_drop;
    logic            w_push;
    logic            w_misalign;
    logic            w_issue_ok;
    logic            w_credit;
    logic [XLEN-1:0] w_target;
    logic [FW-1:0]   w_head;

`ifdef FETCH_ALIGN_CHECK_EN
    logic            r_fault;
    logic [XLEN-1:0] r_fault_pc;
    assign w_misalign  = redirect_valid & (redirect_pc[1:0] != 2'b00);
    assign fetch_fault = r_fault;
    assign fault_pc    = r_fault_pc;
`else
    assign w_misalign  = 1'b0;
    assign fetch_fault = 1'b0;
    assign fault_pc    = '0;
`endif

    always_comb begin
        w_acc        = r_req_valid & imem_req_ready;
        w_pop        = instr_valid & instr_ready;
        // A response arriving with a redirect belongs to the abandoned stream.
        w_drop       = redirect_valid | (r_discard != '0) | (r_state == FAULT);
        w_push       = imem_rsp_valid & ~w_drop;
        w_outst_next = r_outst + CW'(w_acc) - CW'(imem_rsp_valid);
        w_count_next = redirect_valid ? '0 : (w_count + CW'(w_push) - CW'(w_pop));
        w_target     = redirect_pc & ~XLEN'(3);

        if (redirect_valid) begin
            w_discard_next = w_outst_next;
        end else if (imem_rsp_valid && (r_discard != '0)) begin
            w_discard_next = r_discard - CW'(1);
        end else begin
            w_discard_next = r_discard;
        end

        w_state_next = r_state;
        if (w_misalign) begin
            w_state_next = FAULT;
        end else if (redirect_valid) begin
            w_state_next = (w_outst_next != '0) ? DRAIN : RUN;
        end else begin
            case (r_state)
                BOOT:    w_state_next = RUN;
                DRAIN:   w_state_next = (w_discard_next == '0) ? RUN : DRAIN;
                default: w_state_next = r_state;
            endcase
        end

        // Credit counts queued plus in-flight words so a push never overflows.
        w_issue_ok = (r_state != BOOT) && (w_state_next != FAULT);
        w_credit   = ({1'b0, w_count_next} + {1'b0, w_outst_next}) < C_DEPTH;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= BOOT;
            r_req_valid <= 1'b0;
            r_req_addr  <= RESET_PC;
            r_rsp_pc    <= RESET_PC;
            r_outst     <= '0;
            r_discard   <= '0;
`ifdef FETCH_ALIGN_CHECK_EN
            r_fault     <= 1'b0;
            r_fault_pc  <= '0;
`endif
        end else begin
            r_state     <= w_state_next;
            r_outst     <= w_outst_next;
            r_discard   <= w_discard_next;
            r_req_valid <= w_issue_ok & w_credit;
            if (redirect_valid) begin
                if (!w_misalign) begin
                    r_req_addr <= w_target;
                end
                r_rsp_pc <= w_target;
            end else begin
                if (w_acc) begin
                    r_req_addr <= r_req_addr + XLEN'(PC_STEP);
                end
                if (w_push) begin
                    r_rsp_pc <= r_rsp_pc + XLEN'(PC_STEP);
                end
            end
`ifdef FETCH_ALIGN_CHECK_EN
            if (redirect_valid) begin
                r_fault    <= w_misalign;
                r_fault_pc <= w_misalign ? redirect_pc : '0;
            end
`endif
        end
    end

    fetch_fifo #(
        .WIDTH (FW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_data  ({r_rsp_pc, imem_rsp_data}),
        .i_pop   (w_pop),
        .i_flush (redirect_valid),
        .o_data  (w_head),
        .o_count (w_count)
    );

    assign imem_req_valid = r_req_valid;
    assign imem_req_addr  = r_req_addr;
    assign instr_valid    = (w_count != '0);
    assign instr          = w_head[31:0];
    assign instr_pc       = w_head[FW-1:32];

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_fetch_unit
// Description : Directed bench for fetch_unit with a fixed-latency memory.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready;
    logic        fetch_fault;
    logic [31:0] fault_pc;

    logic        w2_req_valid;
    logic [31:0] w2_req_addr;
    logic        w2_instr_valid;
    logic [31:0] w2_instr;
    logic [31:0] w2_instr_pc;
    logic        w2_fault;
    logic [31:0] w2_fault_pc;

    always #5 clk = ~clk;

    fetch_unit u_dut (
        .clk(clk), .rst(rst),
        .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr), .imem_req_ready(imem_req_ready),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc), .instr_ready(instr_ready),
        .fetch_fault(fetch_fault), .fault_pc(fault_pc)
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) u_dut_wrap (
        .clk(clk), .rst(rst),
        .imem_req_valid(w2_req_valid), .imem_req_addr(w2_req_addr), .imem_req_ready(1'b1),
        .imem_rsp_valid(1'b0), .imem_rsp_data(32'h0),
        .redirect_valid(1'b0), .redirect_pc(32'h0),
        .instr_valid(w2_instr_valid), .instr(w2_instr), .instr_pc(w2_instr_pc), .instr_ready(1'b1),
        .fetch_fault(w2_fault), .fault_pc(w2_fault_pc)
    );

    typedef struct { int due; logic [31:0] a; } mreq_t;
    typedef struct { logic [31:0] pc; logic [31:0] w; } pop_t;

    mreq_t       mq[$];
    pop_t        pop_log[$];
    logic [31:0] req_log[$];
    logic [31:0] req_log2[$];
    int          lat = 1;
    int          cyc = 0;
    int          n_cmp = 0;
    int          n_bad = 0;

    function automatic logic [31:0] word(input logic [31:0] a);
        return a ^ 32'hDEAD_BEEF;
    endfunction

    // In-order memory: a request accepted at edge c returns lat cycles later.
    initial begin : mem_model
        logic        acc;
        logic [31:0] a;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        forever begin
            @(negedge clk);
            acc = !rst && imem_req_valid && imem_req_ready;
            a   = imem_req_addr;
            @(posedge clk);
            #1;
            cyc++;
            if (rst) begin
                mq.delete();
                imem_rsp_valid = 1'b0;
            end else begin
                if (acc) begin
                    mq.push_back('{cyc + lat - 1, a});
                    req_log.push_back(a);
                end
                if (mq.size() > 0 && mq[0].due <= cyc) begin
                    imem_rsp_valid = 1'b1;
                    imem_rsp_data  = word(mq[0].a);
                    void'(mq.pop_front());
                end else begin
                    imem_rsp_valid = 1'b0;
                    imem_rsp_data  = 32'h0;
                end
            end
        end
    end

    initial begin : monitors
        forever begin
            @(negedge clk);
            if (!rst && instr_valid && instr_ready) pop_log.push_back('{instr_pc, instr});
            if (!rst && w2_req_valid) req_log2.push_back(w2_req_addr);
        end
    end

    task automatic nxt();
        @(negedge clk);
        #1;
    endtask

    task automatic assert_reset(input int l);
        @(posedge clk);
        #2;
        rst = 1'b1; imem_req_ready = 1'b1; instr_ready = 1'b1;
        redirect_valid = 1'b0; redirect_pc = 32'h0; lat = l;
        repeat (2) @(posedge clk);
    endtask

    task automatic release_reset();
        @(posedge clk);
        #2;
        req_log.delete(); req_log2.delete(); pop_log.delete();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        assert_reset(1);
        nxt();
        n_cmp++; if (imem_req_valid !== 1'b0) begin n_bad++; $display("FAIL rst_req_valid: got %b want 0", imem_req_valid); end
        n_cmp++; if (imem_req_addr !== 32'h0) begin n_bad++; $display("FAIL rst_req_addr: got %h want 0", imem_req_addr); end
        n_cmp++; if (instr_valid !== 1'b0) begin n_bad++; $display("FAIL rst_instr_valid: got %b want 0", instr_valid); end
        n_cmp++; if (instr !== 32'h0 || instr_pc !== 32'h0) begin n_bad++; $display("FAIL rst_instr: got %h/%h want 0/0", instr, instr_pc); end
        n_cmp++; if (fetch_fault !== 1'b0 || fault_pc !== 32'h0) begin n_bad++; $display("FAIL rst_fault: got %b/%h want 0/0", fetch_fault, fault_pc); end
        n_cmp++; if (w2_req_addr !== 32'hFFFF_FFF8) begin n_bad++; $display("FAIL rst_wrap_addr: got %h want fffffff8", w2_req_addr); end
        release_reset();
        nxt(); nxt();
        n_cmp++; if (imem_req_valid !== 1'b0) begin n_bad++; $display("FAIL boot_req_valid: got %b want 0", imem_req_valid); end
        nxt();
        n_cmp++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin n_bad++; $display("FAIL first_req: got %b/%h want 1/0", imem_req_valid, imem_req_addr); end
    endtask

    task automatic test_stream();
        assert_reset(1);
        release_reset();
        repeat (4) nxt();
        n_cmp++; if (instr_valid !== 1'b0) begin n_bad++; $display("FAIL stream_early: got %b want 0", instr_valid); end
        nxt();
        n_cmp++; if (instr_valid !== 1'b1 || instr_pc !== 32'h0 || instr !== word(32'h0)) begin n_bad++; $display("FAIL stream_first: got %b/%h/%h want 1/0/%h", instr_valid, instr_pc, instr, word(32'h0)); end
        repeat (7) nxt();
        n_cmp++; if (pop_log.size() !== 8) begin n_bad++; $display("FAIL stream_pop_count: got %0d want 8", pop_log.size()); end
        for (int i = 0; i < 8 && i < pop_log.size(); i++) begin
            n_cmp++; if (pop_log[i].pc !== 32'(4*i) || pop_log[i].w !== word(32'(4*i))) begin n_bad++; $display("FAIL stream_pop%0d: got %h/%h want %h", i, pop_log[i].pc, pop_log[i].w, 32'(4*i)); end
        end
        n_cmp++; if (req_log.size() < 8) begin n_bad++; $display("FAIL stream_req_count: got %0d want >=8", req_log.size()); end
        for (int i = 0; i < 8 && i < req_log.size(); i++) begin
            n_cmp++; if (req_log[i] !== 32'(4*i)) begin n_bad++; $display("FAIL stream_req%0d: got %h want %h", i, req_log[i], 32'(4*i)); end
        end
    endtask

    task automatic test_stall();
        assert_reset(3);
        release_reset();
        instr_ready = 1'b0;
        repeat (20) nxt();
        n_cmp++; if (req_log.size() !== 4) begin n_bad++; $display("FAIL stall_req_count: got %0d want 4", req_log.size()); end
        n_cmp++; if (imem_req_valid !== 1'b0) begin n_bad++; $display("FAIL stall_req_valid: got %b want 0", imem_req_valid); end
        n_cmp++; if (instr_valid !== 1'b1 || instr_pc !== 32'h0) begin n_bad++; $display("FAIL stall_head: got %b/%h want 1/0", instr_valid, instr_pc); end
        @(posedge clk);
        #2;
        instr_ready = 1'b1;
        nxt();
        n_cmp++; if (imem_req_valid !== 1'b0) begin n_bad++; $display("FAIL stall_before_pop: got %b want 0", imem_req_valid); end
        nxt();
        n_cmp++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h10) begin n_bad++; $display("FAIL stall_resume: got %b/%h want 1/10", imem_req_valid, imem_req_addr); end
        repeat (8) nxt();
        for (int i = 0; i < 5; i++) begin
            n_cmp++; if (i >= pop_log.size() || pop_log[i].pc !== 32'(4*i)) begin n_bad++; $display("FAIL stall_pop%0d: size %0d want pc %h", i, pop_log.size(), 32'(4*i)); end
        end
    endtask

    task automatic test_redirect();
        assert_reset(3);
        release_reset();
        for (int k = 0; k < 20 && req_log.size() < 2; k++) begin
            @(posedge clk);
            #2;
        end
        n_cmp++; if (req_log.size() !== 2) begin n_bad++; $display("FAIL redir_inflight: got %0d want 2", req_log.size()); end
        imem_req_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h100;
        @(posedge clk);
        #2;
        redirect_valid = 1'b0; imem_req_ready = 1'b1; pop_log.delete();
        nxt();
        n_cmp++; if (instr_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 32'h100) begin n_bad++; $display("FAIL redir_next: got %b/%b/%h want 0/1/100", instr_valid, imem_req_valid, imem_req_addr); end
        repeat (12) nxt();
        for (int i = 0; i < 4; i++) begin
            n_cmp++; if (i >= pop_log.size() || pop_log[i].pc !== 32'h100 + 32'(4*i) || pop_log[i].w !== word(32'h100 + 32'(4*i))) begin n_bad++; $display("FAIL redir_pop%0d: size %0d want pc %h", i, pop_log.size(), 32'h100 + 32'(4*i)); end
        end
    endtask

    task automatic test_back_to_back();
        assert_reset(1);
        release_reset();
        repeat (8) nxt();
        @(posedge clk);
        #2;
        redirect_valid = 1'b1; redirect_pc = 32'h200;
        nxt();
        n_cmp++; if (imem_rsp_valid !== 1'b1 || imem_req_valid !== 1'b1) begin n_bad++; $display("FAIL b2b_setup: got rsp %b req %b want 1/1", imem_rsp_valid, imem_req_valid); end
        @(posedge clk);
        #2;
        redirect_valid = 1'b0; pop_log.delete();
        nxt();
        n_cmp++; if (instr_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 32'h200) begin n_bad++; $display("FAIL b2b_n1: got %b/%b/%h want 0/1/200", instr_valid, imem_req_valid, imem_req_addr); end
        nxt();
        n_cmp++; if (instr_valid !== 1'b0) begin n_bad++; $display("FAIL b2b_n2: got %b want 0", instr_valid); end
        nxt();
        n_cmp++; if (instr_valid !== 1'b1 || instr_pc !== 32'h200 || instr !== word(32'h200)) begin n_bad++; $display("FAIL b2b_n3: got %b/%h/%h want 1/200/%h", instr_valid, instr_pc, instr, word(32'h200)); end
        repeat (4) nxt();
        for (int i = 0; i < 4; i++) begin
            n_cmp++; if (i >= pop_log.size() || pop_log[i].pc !== 32'h200 + 32'(4*i) || pop_log[i].w !== word(32'h200 + 32'(4*i))) begin n_bad++; $display("FAIL b2b_pop%0d: size %0d want pc %h", i, pop_log.size(), 32'h200 + 32'(4*i)); end
        end
    endtask

    task automatic test_wrap();
        assert_reset(1);
        release_reset();
        repeat (10) nxt();
        n_cmp++; if (req_log2.size() !== 4) begin n_bad++; $display("FAIL wrap_count: got %0d want 4", req_log2.size()); end
        n_cmp++; if (req_log2.size() < 3 || req_log2[0] !== 32'hFFFF_FFF8 || req_log2[1] !== 32'hFFFF_FFFC || req_log2[2] !== 32'h0) begin n_bad++; $display("FAIL wrap_addrs: size %0d want fffffff8 fffffffc 00000000", req_log2.size()); end
    endtask

    task automatic test_misaligned();
        int n;
        assert_reset(1);
        release_reset();
        repeat (8) nxt();
        @(posedge clk);
        #2;
        redirect_valid = 1'b1; redirect_pc = 32'h102;
        @(posedge clk);
        #2;
        redirect_valid = 1'b0; pop_log.delete();
        nxt();
`ifdef FETCH_ALIGN_CHECK_EN
        n_cmp++; if (fetch_fault !== 1'b1 || fault_pc !== 32'h102) begin n_bad++; $display("FAIL fault_set: got %b/%h want 1/102", fetch_fault, fault_pc); end
        n_cmp++; if (imem_req_valid !== 1'b0 || instr_valid !== 1'b0) begin n_bad++; $display("FAIL fault_quiet: got req %b instr %b want 0/0", imem_req_valid, instr_valid); end
        n = req_log.size();
        repeat (6) nxt();
        n_cmp++; if (fetch_fault !== 1'b1 || imem_req_valid !== 1'b0 || req_log.size() !== n || pop_log.size() !== 0) begin n_bad++; $display("FAIL fault_hold: got %b/%b/%0d/%0d want 1/0/%0d/0", fetch_fault, imem_req_valid, req_log.size(), pop_log.size(), n); end
        @(posedge clk);
        #2;
        redirect_valid = 1'b1; redirect_pc = 32'h200;
        @(posedge clk);
        #2;
        redirect_valid = 1'b0;
        nxt();
        n_cmp++; if (fetch_fault !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 32'h200) begin n_bad++; $display("FAIL fault_exit: got %b/%b/%h want 0/1/200", fetch_fault, imem_req_valid, imem_req_addr); end
        repeat (4) nxt();
        n_cmp++; if (pop_log.size() == 0 || pop_log[0].pc !== 32'h200 || pop_log[0].w !== word(32'h200)) begin n_bad++; $display("FAIL fault_resume: size %0d want pc 200", pop_log.size()); end
`else
        n = 0;
        n_cmp++; if (fetch_fault !== 1'b0 || fault_pc !== 32'h0) begin n_bad++; $display("FAIL noalign_fault: got %b/%h want 0/0", fetch_fault, fault_pc); end
        n_cmp++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h100) begin n_bad++; $display("FAIL noalign_req: got %b/%h want 1/100", imem_req_valid, imem_req_addr); end
        repeat (4) nxt();
        n_cmp++; if (pop_log.size() == n || pop_log[0].pc !== 32'h100 || pop_log[0].w !== word(32'h100)) begin n_bad++; $display("FAIL noalign_resume: size %0d want pc 100", pop_log.size()); end
`endif
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : main
        rst = 1'b1;
        imem_req_ready = 1'b1;
        instr_ready = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc = 32'h0;
        test_reset();
        test_stream();
        test_stall();
        test_redirect();
        test_back_to_back();
        test_wrap();
        test_misaligned();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
